// File: rtl/aes_proto_monitor.sv
// Per-channel load/decrypt/done protocol monitor for AES cores: tracks each
// transaction's latency, counts encrypt/decrypt loads and latches sticky errors.
module aes_proto_monitor #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int MIN_LAT = 10,
   parameter int MAX_LAT = 12,
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LAT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] load_i,
   input  logic [NUM_CH-1:0] decrypt_i,
   input  logic [NUM_CH-1:0] done_i,
   input  logic              clr_i,
   input  logic [4:0]        err_en_i,
   input  logic [SEL_W-1:0]  sel_i,
   output logic [CNT_W-1:0]  enc_cnt_o,
   output logic [CNT_W-1:0]  dec_cnt_o,
   output logic [4:0]        err_o,
   output logic [NUM_CH-1:0] busy_o,
   output logic [NUM_CH-1:0] cov_done_o,
   output logic              irq_o
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   localparam int E_LOAD_BUSY = 0;
   localparam int E_SPURIOUS  = 1;
   localparam int E_TIMEOUT   = 2;
   localparam int E_EARLY     = 3;
   localparam int E_MODE      = 4;

   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MAX_LAT - 1);
   localparam logic [LAT_W-1:0] LAT_EARLY = LAT_W'(MIN_LAT - 1);

   state_e           state_q [NUM_CH];
   state_e           state_d [NUM_CH];
   logic [LAT_W-1:0] lat_q   [NUM_CH];
   logic [LAT_W-1:0] lat_d   [NUM_CH];
   logic             mode_q  [NUM_CH];
   logic             mode_d  [NUM_CH];
   logic [CNT_W-1:0] enc_q   [NUM_CH];
   logic [CNT_W-1:0] enc_d   [NUM_CH];
   logic [CNT_W-1:0] dec_q   [NUM_CH];
   logic [CNT_W-1:0] dec_d   [NUM_CH];
   logic [4:0]       err_q   [NUM_CH];
   logic [4:0]       err_d   [NUM_CH];
   logic [NUM_CH-1:0] cov_q, cov_d, busy_q, busy_d;
   logic [CNT_W-1:0] rd_enc_q, rd_enc_d, rd_dec_q, rd_dec_d;
   logic [4:0]       rd_err_q, rd_err_d;
   logic             irq_q, irq_d;
   logic             accept;

   // Clear is applied first so that same-cycle events land on the zeroed state.
   always_comb begin
      accept = 1'b0;
      busy_d = '0;
      cov_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         lat_d[i]   = lat_q[i];
         mode_d[i]  = mode_q[i];
         enc_d[i]   = clr_i ? '0 : enc_q[i];
         dec_d[i]   = clr_i ? '0 : dec_q[i];
         err_d[i]   = clr_i ? '0 : err_q[i];
         accept     = 1'b0;
         case (state_q[i])
            IDLE: begin
               if (done_i[i]) err_d[i][E_SPURIOUS] = 1'b1;
               accept = load_i[i];
            end
            BUSY: begin
               if (done_i[i]) begin
                  if (lat_q[i] < LAT_EARLY) err_d[i][E_EARLY] = 1'b1;
                  accept = load_i[i];
                  if (!load_i[i]) state_d[i] = IDLE;
               end else begin
                  if (load_i[i]) err_d[i][E_LOAD_BUSY] = 1'b1;
                  if (decrypt_i[i] != mode_q[i]) err_d[i][E_MODE] = 1'b1;
                  if (lat_q[i] == LAT_LAST) begin
                     err_d[i][E_TIMEOUT] = 1'b1;
                     state_d[i] = IDLE;
                  end else begin
                     lat_d[i] = lat_q[i] + LAT_W'(1);
                  end
               end
            end
            default: state_d[i] = IDLE;
         endcase
         if (accept) begin
            state_d[i] = BUSY;
            lat_d[i]   = '0;
            mode_d[i]  = decrypt_i[i];
            if (decrypt_i[i]) begin
               if (dec_d[i] != '1) dec_d[i] = dec_d[i] + CNT_W'(1);
            end else begin
               if (enc_d[i] != '1) enc_d[i] = enc_d[i] + CNT_W'(1);
            end
         end
         busy_d[i] = (state_d[i] == BUSY);
         cov_d[i]  = (enc_d[i] != '0) && (dec_d[i] != '0);
      end
   end

   // Readout samples the settled per-channel state, so it lags updates by one edge.
   always_comb begin
      rd_enc_d = '0;
      rd_dec_d = '0;
      rd_err_d = '0;
      irq_d    = 1'b0;
      if (32'(sel_i) < NUM_CH) begin
         rd_enc_d = enc_q[sel_i];
         rd_dec_d = dec_q[sel_i];
         rd_err_d = err_q[sel_i];
      end
      for (int i = 0; i < NUM_CH; i++) begin
         irq_d = irq_d | (|(err_q[i] & err_en_i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            lat_q[i]   <= '0;
            mode_q[i]  <= 1'b0;
            enc_q[i]   <= '0;
            dec_q[i]   <= '0;
            err_q[i]   <= '0;
         end
         busy_q   <= '0;
         cov_q    <= '0;
         rd_enc_q <= '0;
         rd_dec_q <= '0;
         rd_err_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            lat_q[i]   <= lat_d[i];
            mode_q[i]  <= mode_d[i];
            enc_q[i]   <= enc_d[i];
            dec_q[i]   <= dec_d[i];
            err_q[i]   <= err_d[i];
         end
         busy_q   <= busy_d;
         cov_q    <= cov_d;
         rd_enc_q <= rd_enc_d;
         rd_dec_q <= rd_dec_d;
         rd_err_q <= rd_err_d;
         irq_q    <= irq_d;
      end
   end

   assign enc_cnt_o  = rd_enc_q;
   assign dec_cnt_o  = rd_dec_q;
   assign err_o      = rd_err_q;
   assign busy_o     = busy_q;
   assign cov_done_o = cov_q;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_aes_proto_monitor.sv
// Scenario bench for aes_proto_monitor (NUM_CH=4, CNT_W=4 for saturation, latency window 10..12).
module tb_aes_proto_monitor;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] load_i = '0;
   logic [NUM_CH-1:0] decrypt_i = '0;
   logic [NUM_CH-1:0] done_i = '0;
   logic              clr_i = 1'b0;
   logic [4:0]        err_en_i = '0;
   logic [1:0]        sel_i = '0;
   logic [CNT_W-1:0]  enc_cnt_o, dec_cnt_o;
   logic [4:0]        err_o;
   logic [NUM_CH-1:0] busy_o, cov_done_o;
   logic              irq_o;

   // Readout word layout: {err[4:0], dec_cnt[3:0], enc_cnt[3:0]}
   logic [12:0] exp_q[$];
   logic [12:0] got, exp_v;
   int checks = 0;
   int errors = 0;

   aes_proto_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_LAT(10), .MAX_LAT(12)) dut (
      .clk(clk), .rst(rst), .load_i(load_i), .decrypt_i(decrypt_i), .done_i(done_i),
      .clr_i(clr_i), .err_en_i(err_en_i), .sel_i(sel_i), .enc_cnt_o(enc_cnt_o),
      .dec_cnt_o(dec_cnt_o), .err_o(err_o), .busy_o(busy_o), .cov_done_o(cov_done_o),
      .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic read_ch(input int ch, output logic [12:0] val);
      sel_i = 2'(ch);
      cyc();
      val = {err_o, dec_cnt_o, enc_cnt_o};
   endtask

   // Load at edge 0 with mode held; done at edge done_at; returns #1 after that edge.
   task automatic drive_txn(input int ch, input bit dec, input int done_at);
      for (int k = 0; k <= done_at; k++) begin
         load_i[ch]    = (k == 0);
         decrypt_i[ch] = dec;
         done_i[ch]    = (k == done_at);
         cyc();
      end
      load_i = '0; done_i = '0; decrypt_i = '0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy_o, cov_done_o, irq_o, enc_cnt_o, dec_cnt_o, err_o} !== '0) begin
         errors++; $display("FAIL reset_in_reset got %h exp 0", {busy_o, cov_done_o, irq_o, enc_cnt_o, dec_cnt_o, err_o});
      end
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      checks++;
      if ({busy_o, cov_done_o, irq_o} !== '0) begin
         errors++; $display("FAIL reset_after_release got %h exp 0", {busy_o, cov_done_o, irq_o});
      end
      exp_q.push_back(13'h0);
      read_ch(0, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_readout got %h exp %h", got, exp_v); end
   endtask

   task automatic test_encrypt();
      bit busy_ok = 1'b1;
      load_i[0] = 1'b1;
      cyc();
      load_i[0] = 1'b0;
      if (busy_o[0] !== 1'b1) busy_ok = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         if (busy_o[0] !== 1'b1) busy_ok = 1'b0;
      end
      checks++;
      if (!busy_ok) begin errors++; $display("FAIL enc_busy_window got 0 exp 1"); end
      done_i[0] = 1'b1;
      cyc();
      done_i[0] = 1'b0;
      checks++;
      if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL enc_busy_drop got %b exp 0", busy_o[0]); end
      exp_q.push_back({5'b00000, 4'd0, 4'd1});
      read_ch(0, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL enc_readout got %h exp %h", got, exp_v); end
   endtask

   task automatic test_coverage();
      err_en_i = 5'b01000;
      drive_txn(1, 1'b0, 10);
      drive_txn(1, 1'b1, 12);
      exp_q.push_back({5'b00000, 4'd1, 4'd1});
      checks++;
      if (cov_done_o !== 4'b0010) begin errors++; $display("FAIL cov_done got %b exp 0010", cov_done_o); end
      read_ch(1, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL cov_readout got %h exp %h", got, exp_v); end
      drive_txn(1, 1'b1, 9);
      exp_q.push_back({5'b01000, 4'd2, 4'd1});
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL early_irq_lat got %b exp 0", irq_o); end
      cyc();
      checks++;
      if (irq_o !== 1'b1) begin errors++; $display("FAIL early_irq got %b exp 1", irq_o); end
      read_ch(1, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL early_readout got %h exp %h", got, exp_v); end
      err_en_i = '0;
      clr_i = 1'b1;
      cyc();
      clr_i = 1'b0;
      cyc();
      cyc();
      checks++;
      if ({irq_o, cov_done_o} !== '0) begin errors++; $display("FAIL clear_irq_cov got %h exp 0", {irq_o, cov_done_o}); end
   endtask

   task automatic test_timeout();
      bit b11 = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         load_i[2] = (k == 0);
         cyc();
         if (k == 11) b11 = busy_o[2];
      end
      load_i = '0;
      checks++;
      if (b11 !== 1'b1) begin errors++; $display("FAIL timeout_busy_last got %b exp 1", b11); end
      checks++;
      if (busy_o[2] !== 1'b0) begin errors++; $display("FAIL timeout_busy_drop got %b exp 0", busy_o[2]); end
      exp_q.push_back({5'b00100, 4'd0, 4'd1});
      read_ch(2, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL timeout_readout got %h exp %h", got, exp_v); end
      done_i[2] = 1'b1;
      cyc();
      done_i[2] = 1'b0;
      exp_q.push_back({5'b00110, 4'd0, 4'd1});
      read_ch(2, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL spurious_readout got %h exp %h", got, exp_v); end
   endtask

   task automatic test_misuse();
      for (int k = 0; k <= 11; k++) begin
         load_i[3]    = (k == 0 || k == 3);
         decrypt_i[3] = (k == 5);
         done_i[3]    = (k == 11);
         cyc();
      end
      load_i = '0; decrypt_i = '0; done_i = '0;
      exp_q.push_back({5'b10001, 4'd0, 4'd1});
      read_ch(3, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL misuse_readout got %h exp %h", got, exp_v); end
   endtask

   task automatic test_clear_load();
      clr_i = 1'b1; load_i[2] = 1'b1; decrypt_i[2] = 1'b1; done_i[2] = 1'b1;
      cyc();
      clr_i = 1'b0; load_i = '0; done_i = '0;
      for (int k = 1; k <= 10; k++) begin
         done_i[2] = (k == 10);
         cyc();
      end
      done_i = '0; decrypt_i = '0;
      exp_q.push_back({5'b00010, 4'd1, 4'd0});
      exp_q.push_back(13'h0);
      read_ch(2, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL clear_load_readout got %h exp %h", got, exp_v); end
      read_ch(3, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL clear_other_readout got %h exp %h", got, exp_v); end
   endtask

   task automatic test_back_to_back();
      bit b10 = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         load_i[0] = (k == 0 || k == 10);
         done_i[0] = (k == 10 || k == 20);
         cyc();
         if (k == 10) b10 = busy_o[0];
      end
      load_i = '0; done_i = '0;
      checks++;
      if (b10 !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", b10); end
      exp_q.push_back({5'b00000, 4'd0, 4'd2});
      read_ch(0, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL b2b_readout got %h exp %h", got, exp_v); end
   endtask

   task automatic test_saturation();
      for (int k = 0; k <= 200; k++) begin
         load_i[1] = (k % 10 == 0) && (k < 200);
         done_i[1] = (k % 10 == 0) && (k > 0);
         cyc();
      end
      load_i = '0; done_i = '0;
      exp_q.push_back({5'b00000, 4'd0, 4'd15});
      read_ch(1, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL sat_readout got %h exp %h", got, exp_v); end
   endtask

   task automatic test_async_reset();
      err_en_i = 5'b11111;
      sel_i = 2'd0;
      load_i[0] = 1'b1;
      cyc();
      cyc();
      cyc();
      load_i[0] = 1'b0;
      repeat (3) cyc();
      checks++;
      if ({irq_o, err_o, busy_o[0]} !== 7'b1_00001_1) begin
         errors++; $display("FAIL pre_reset_state got %b exp 1000011", {irq_o, err_o, busy_o[0]});
      end
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy_o, irq_o, err_o, enc_cnt_o, cov_done_o} !== '0) begin
         errors++; $display("FAIL async_reset got %h exp 0", {busy_o, irq_o, err_o, enc_cnt_o, cov_done_o});
      end
      cyc();
      cyc();
      rst = 1'b0;
      err_en_i = '0;
      done_i[0] = 1'b1;
      cyc();
      done_i[0] = 1'b0;
      exp_q.push_back({5'b00010, 4'd0, 4'd0});
      read_ch(0, got); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL post_reset_readout got %h exp %h", got, exp_v); end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_coverage();
      test_timeout();
      test_misuse();
      test_clear_load();
      test_back_to_back();
      test_saturation();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
